jk_bank_sequencer: RTL and testbench

Command-driven controller for a WIDTH-bit bank of JK flip-flops. It accepts one command at a time over a valid/ready handshake and drives the bank's J/K inputs for a programmed number of clock cycles. Supported operations are hold, set, clear, toggle, load, and JK-style binary up/down count. The bank state q is owned by this block and exposed as an output. The block sits between lab-level stimulus/control logic and the flip-flop datapath.

---
 rtl/jk_bank_sequencer.sv | 137 +++++++++++++
 tb/tb_jk_bank_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer.sv
// rtl/jk_bank_sequencer.sv - command-driven J/K drive sequencer for a WIDTH-bit JK flip-flop bank
// Owns the bank state q and applies one latched op for cmd_repeat+1 cycles.
module jk_bank_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [3:0]       cmd_repeat,
  input  logic             abort,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_SET    = 3'b001;
  localparam logic [2:0] OP_CLEAR  = 3'b010;
  localparam logic [2:0] OP_TOGGLE = 3'b011;
  localparam logic [2:0] OP_UP     = 3'b100;
  localparam logic [2:0] OP_DOWN   = 3'b101;
  localparam logic [2:0] OP_LOAD   = 3'b110;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [3:0]       r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_data;

  logic [WIDTH-1:0] w_t_up;
  logic [WIDTH-1:0] w_t_dn;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_j_app;
  logic [WIDTH-1:0] w_k_app;
  logic [WIDTH-1:0] w_q_next;
  logic             w_accept;

  // Ripple-carry toggle enables: bit i flips when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    logic w_all_one;
    logic w_all_zero;
    w_t_up     = '0;
    w_t_dn     = '0;
    w_all_one  = 1'b1;
    w_all_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_t_up[i]  = r_mask[i] & w_all_one;
      w_t_dn[i]  = r_mask[i] & w_all_zero;
      w_all_one  = w_all_one & r_q[i];
      w_all_zero = w_all_zero & ~r_q[i];
    end
  end

  always_comb begin
    w_j = '0;
    w_k = '0;
    if (r_state == S_APPLY) begin
      case (r_op)
        OP_SET:    w_j = r_mask;
        OP_CLEAR:  w_k = r_mask;
        OP_TOGGLE: begin w_j = r_mask; w_k = r_mask; end
        OP_UP:     begin w_j = w_t_up; w_k = w_t_up; end
        OP_DOWN:   begin w_j = w_t_dn; w_k = w_t_dn; end
        OP_LOAD:   begin w_j = r_mask & r_data; w_k = r_mask & ~r_data; end
        OP_HOLD:   ;
        default:   ;
      endcase
    end
  end

  // Abort suppresses the bank update internally so j/k stay free of any input-to-output path.
  assign w_j_app  = abort ? '0 : w_j;
  assign w_k_app  = abort ? '0 : w_k;
  assign w_q_next = (w_j_app & ~r_q) | (~w_k_app & r_q);
  assign w_accept = (r_state == S_IDLE) && cmd_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid) w_state_next = S_APPLY;
      S_APPLY: if (abort || (r_cnt == 4'd0)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= '0;
      r_cnt  <= '0;
      r_op   <= '0;
      r_mask <= '0;
      r_data <= '0;
    end else begin
      r_q <= w_q_next;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_mask <= cmd_mask;
        r_data <= cmd_data;
        r_cnt  <= cmd_repeat;
      end else if ((r_state == S_APPLY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign j         = w_j;
  assign k         = w_k;
  assign q         = r_q;
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb/tb_jk_bank_sequencer.sv - directed self-checking bench for jk_bank_sequencer
module tb_jk_bank_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [3:0] cmd_mask = 4'b0000;
  logic [3:0] cmd_data = 4'b0000;
  logic [3:0] cmd_repeat = 4'd0;
  logic       abort = 1'b0;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  jk_bank_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_data(cmd_data), .cmd_repeat(cmd_repeat),
    .abort(abort), .j(j), .k(k), .q(q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command and steps through its accept edge.
  task automatic send(input logic [2:0] op, input logic [3:0] mask, input logic [3:0] data,
                      input logic [3:0] rep);
    cmd_op = op; cmd_mask = mask; cmd_data = data; cmd_repeat = rep;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    vectors++;
    if (q !== 4'b0000) begin miscompares++; $display("FAIL reset_q got=%b exp=0000", q); end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    vectors++;
    if (j !== 4'b0000 || k !== 4'b0000) begin miscompares++; $display("FAIL reset_jk got=%b/%b exp=0000/0000", j, k); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_command();
    send(3'b011, 4'b1111, 4'b0000, 4'd15);
    vectors++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got=%b%b exp=10", busy, cmd_ready); end
    vectors++;
    if (j !== 4'b1111 || k !== 4'b1111) begin miscompares++; $display("FAIL midrst_jk got=%b/%b exp=1111/1111", j, k); end
    tick(); tick(); tick();
    vectors++;
    if (q !== 4'b1111) begin miscompares++; $display("FAIL midrst_pre_q got=%b exp=1111", q); end
    #1 reset = 1'b0;
    #1;
    vectors++;
    if (q !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_async got q=%b busy=%b done=%b ready=%b exp q=0000 busy=0 done=0 ready=1", q, busy, done, cmd_ready);
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || q !== 4'b0000) begin
        miscompares++;
        $display("FAIL midrst_after%0d got done=%b busy=%b q=%b exp 0 0 0000", i, done, busy, q);
      end
    end
  endtask

  task automatic test_set_clear();
    send(3'b001, 4'b0101, 4'b0000, 4'd0);
    tick();
    vectors++;
    if (q !== 4'b0101 || done !== 1'b1) begin miscompares++; $display("FAIL set_e1 got q=%b done=%b exp q=0101 done=1", q, done); end
    tick();
    vectors++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL set_e2 got done=%b ready=%b exp 0 1", done, cmd_ready); end
    send(3'b010, 4'b0001, 4'b0000, 4'd0);
    tick();
    vectors++;
    if (q !== 4'b0100 || done !== 1'b1) begin miscompares++; $display("FAIL clear_e1 got q=%b done=%b exp q=0100 done=1", q, done); end
    tick();
  endtask

  task automatic test_count_wrap();
    logic [3:0] up_exp [4];
    logic [3:0] dn_exp [3];
    up_exp = '{4'b1111, 4'b0000, 4'b0001, 4'b0010};
    dn_exp = '{4'b0001, 4'b0000, 4'b1111};
    send(3'b110, 4'b1111, 4'b1110, 4'd0);
    tick();
    vectors++;
    if (q !== 4'b1110) begin miscompares++; $display("FAIL load got=%b exp=1110", q); end
    tick();
    send(3'b100, 4'b1111, 4'b0000, 4'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (q !== up_exp[i] || done !== (i == 3)) begin
        miscompares++;
        $display("FAIL count_up%0d got q=%b done=%b exp q=%b done=%b", i, q, done, up_exp[i], (i == 3));
      end
    end
    tick();
    send(3'b101, 4'b1111, 4'b0000, 4'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (q !== dn_exp[i] || done !== (i == 2)) begin
        miscompares++;
        $display("FAIL count_dn%0d got q=%b done=%b exp q=%b done=%b", i, q, done, dn_exp[i], (i == 2));
      end
    end
    tick();
  endtask

  task automatic test_toggle_repeat();
    send(3'b010, 4'b1111, 4'b0000, 4'd0);
    tick(); tick();
    send(3'b011, 4'b1001, 4'b0000, 4'd4);
    for (int i = 1; i <= 5; i++) begin
      tick();
      vectors++;
      if (q !== ((i % 2 == 1) ? 4'b1001 : 4'b0000) || done !== (i == 5)) begin
        miscompares++;
        $display("FAIL toggle_e%0d got q=%b done=%b exp q=%b done=%b", i, q, done,
                 ((i % 2 == 1) ? 4'b1001 : 4'b0000), (i == 5));
      end
    end
    tick();
    vectors++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL toggle_e6 got done=%b ready=%b exp 0 1", done, cmd_ready); end
  endtask

  task automatic test_abort();
    send(3'b010, 4'b1111, 4'b0000, 4'd0);
    tick(); tick();
    send(3'b011, 4'b1111, 4'b0000, 4'd15);
    tick(); tick();
    vectors++;
    if (q !== 4'b0000 || done !== 1'b0) begin miscompares++; $display("FAIL abort_pre got q=%b done=%b exp 0000 0", q, done); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (q !== 4'b0000 || done !== 1'b1) begin miscompares++; $display("FAIL abort_edge got q=%b done=%b exp 0000 1", q, done); end
    tick();
    vectors++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || q !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort_after got done=%b ready=%b q=%b exp 0 1 0000", done, cmd_ready, q);
    end
  endtask

  task automatic test_handshake();
    send(3'b001, 4'b0011, 4'b0000, 4'd2);
    cmd_op = 3'b010; cmd_mask = 4'b0001; cmd_data = 4'b0000; cmd_repeat = 4'd0;
    cmd_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      vectors++;
      if (q !== 4'b0011 || cmd_ready !== (i == 4)) begin
        miscompares++;
        $display("FAIL hs_hold%0d got q=%b ready=%b exp q=0011 ready=%b", i, q, cmd_ready, (i == 4));
      end
    end
    tick();
    cmd_valid = 1'b0;
    tick();
    vectors++;
    if (q !== 4'b0010 || done !== 1'b1) begin miscompares++; $display("FAIL hs_second got q=%b done=%b exp 0010 1", q, done); end
    tick();
    send(3'b111, 4'b1111, 4'b1010, 4'd2);
    for (int i = 1; i <= 3; i++) begin
      tick();
      vectors++;
      if (q !== 4'b0010 || done !== (i == 3)) begin
        miscompares++;
        $display("FAIL reserved_e%0d got q=%b done=%b exp q=0010 done=%b", i, q, done, (i == 3));
      end
    end
    tick();
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL reserved_end got ready=%b busy=%b exp 1 0", cmd_ready, busy); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_command();
    test_set_clear();
    test_count_wrap();
    test_toggle_repeat();
    test_abort();
    test_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
